vector_element_serializer: RTL and testbench
============================================

Name: vector_element_serializer

Overview:
- Producer-side counterpart of the element index counter in the neural-net datapath.
- Accepts a whole packed vector of ROW_COUNT x ROW_LENGTH elements and streams it out one element per cycle.
- Each output element carries its element index plus row-end and vector-end markers.
- Two vector slots (active + pending) allow back-to-back vectors to stream with no bubble.

Parameters:
- ELEMENT_WIDTH, 8, bits per element.
- ROW_LENGTH, 3, elements per row.
- ROW_COUNT, 3, rows per vector.
- INDEX_WIDTH, 4, width of element_index; ROW_LENGTH*ROW_COUNT <= 2**INDEX_WIDTH is required.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; highest priority after reset.
- vec_valid  in  1  upstream presents a vector.
- vec_ready  out  1  block can take a vector this cycle.
- vec_data  in  ELEMENT_WIDTH*ROW_LENGTH*ROW_COUNT  packed vector; element k occupies bits [k*ELEMENT_WIDTH +: ELEMENT_WIDTH], and element 0 is the LSB slice.
- elem_valid  out  1  element output valid.
- elem_ready  in  1  downstream accepts the element.
- elem_data  out  ELEMENT_WIDTH  current element.
- element_index  out  INDEX_WIDTH  index of the current element, 0..N-1 where N = ROW_LENGTH*ROW_COUNT.
- row_end  out  1  current element is the last in its row: index mod ROW_LENGTH == ROW_LENGTH-1.
- vector_end  out  1  current element is the last in the vector: index == N-1.

Behaviour:
- Reset (async, active-high): active and pending slots empty, element_index = 0, stored data = 0, elem_valid = 0.
  - vec_ready is 1 when the block leaves reset.
  - elem_data, row_end and vector_end read 0 while reset is held.
- Occupancy FSM:
  - EMPTY: no vector held.
  - ONE: active slot full.
  - TWO: active and pending slots full.
- Handshakes:
  - Vector transfer = vec_valid && vec_ready.
  - Element transfer = elem_valid && elem_ready.
- vec_ready = (state != TWO). It is driven from registered state only, with no combinational path from elem_ready.
- elem_valid = (state != EMPTY).
- elem_data = active slice at element_index. row_end and vector_end are decoded from element_index and gated by elem_valid.
- All element outputs hold stable while elem_valid && !elem_ready.
- Transitions:
  - EMPTY + vector transfer -> ONE, index 0. elem_valid rises the next cycle (latency 1).
  - ONE, element transfer not at vector_end -> index + 1.
  - ONE, element transfer at vector_end, no vector transfer -> EMPTY, index 0.
  - ONE, element transfer at vector_end, with vector transfer -> stay ONE; the new vector loads directly into active, index 0.
  - ONE, vector transfer without a vector_end transfer -> TWO; the vector loads into pending.
  - TWO, element transfer at vector_end -> ONE; pending moves to active the same edge, index 0, so there is no idle cycle.
- Throughput: N cycles per vector with elem_ready held high and vectors supplied back-to-back.
- Index never exceeds N-1. It wraps to 0 only on a vector_end transfer.
- clear:
  - Next edge: EMPTY, index 0, both slots invalidated.
  - Any vector or element handshake in the same cycle is discarded.
  - Stored data contents need not be zeroed.
- Reset asserted mid-stream aborts the in-flight vector immediately (async). No partial stream resumes after reset is released.
- vec_data is sampled only on a vector transfer. Changes to vec_data at any other time have no effect.

Test Plan:
- Reset, load vector of elements 0x10..0x18, elem_ready = 1 -> elem_valid one cycle after the load. Sequence:
  - index 0..8, data 0x10..0x18.
  - row_end at index 2, 5, 8.
  - vector_end only at index 8.
  - elem_valid drops after index 8.
- Two vectors offered back-to-back, elem_ready = 1 ->
  - 18 consecutive valid cycles with no gap.
  - vec_ready = 0 while TWO.
  - vec_ready returns to 1 in the cycle after the first vector_end transfer.
- elem_ready toggled 1,0,0,1 pseudo-randomly -> data, index and flags hold during stalls; all 9 elements are delivered in order exactly once.
- vec_valid at the same cycle as a vector_end transfer with pending empty ->
  - the next cycle shows index 0 of the new vector;
  - the state stays ONE and vec_ready stays 1.
- clear at index 4 with a pending vector held -> next cycle elem_valid = 0, vec_ready = 1, index 0; the following load streams from element 0.
- Async reset pulsed mid-cycle at index 6 -> elem_valid = 0 and index = 0 immediately, without waiting for a clock edge; there is no output until a new vector is loaded.

Source files
------------

// File: rtl/vector_element_serializer_if.sv
// Handshake bundle for the vector element serializer.
// Valid/ready rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both high; a producer holding valid keeps
// its payload stable until that transfer, and a consumer may change ready
// at any time.
interface vector_element_serializer_if #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ROW_LENGTH    = 3,
    parameter int ROW_COUNT     = 3,
    parameter int INDEX_WIDTH   = 4
);
    localparam int VEC_WIDTH = ELEMENT_WIDTH * ROW_LENGTH * ROW_COUNT;

    // Vector input channel
    logic                     vec_valid;
    logic                     vec_ready;
    logic [VEC_WIDTH-1:0]     vec_data;

    // Element output channel
    logic                     elem_valid;
    logic                     elem_ready;
    logic [ELEMENT_WIDTH-1:0] elem_data;
    logic [INDEX_WIDTH-1:0]   element_index;
    logic                     row_end;
    logic                     vector_end;

    // Upstream producer / downstream consumer view (drives the serializer)
    modport master (
        output vec_valid,
        output vec_data,
        output elem_ready,
        input  vec_ready,
        input  elem_valid,
        input  elem_data,
        input  element_index,
        input  row_end,
        input  vector_end
    );

    // Serializer view
    modport slave (
        input  vec_valid,
        input  vec_data,
        input  elem_ready,
        output vec_ready,
        output elem_valid,
        output elem_data,
        output element_index,
        output row_end,
        output vector_end
    );
endinterface

// File: rtl/vector_element_serializer.sv
// Vector element serializer: takes a whole packed vector of
// ROW_COUNT x ROW_LENGTH elements and streams it out one element per cycle,
// tagging each element with its index, a row-end and a vector-end marker.
// An active slot feeds the output while a pending slot holds the next
// vector, so back-to-back vectors stream without a bubble.
module vector_element_serializer #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ROW_LENGTH    = 3,
    parameter int ROW_COUNT     = 3,
    parameter int INDEX_WIDTH   = 4
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_clear,
    vector_element_serializer_if.slave     bus,
    output logic [1:0]                     o_dbg_state
);
    localparam int N_ELEMS   = ROW_LENGTH * ROW_COUNT;
    localparam int VEC_WIDTH = ELEMENT_WIDTH * N_ELEMS;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(N_ELEMS - 1);

    // Occupancy: EMPTY = nothing held, ONE = active slot full,
    // TWO = active and pending slots full.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                   r_state;
    logic [INDEX_WIDTH-1:0]   r_index;
    logic [VEC_WIDTH-1:0]     r_active;
    logic [VEC_WIDTH-1:0]     r_pending;
    logic                     r_vec_ready;
    logic                     r_elem_valid;

    logic                     w_vec_xfer;
    logic                     w_elem_xfer;
    logic                     w_at_last;
    logic [ELEMENT_WIDTH-1:0] w_elem_data;
    logic                     w_row_end_raw;

    // Both ready/valid outputs come from registers, so there is no
    // combinational path from elem_ready back to vec_ready.
    assign w_vec_xfer  = bus.vec_valid && r_vec_ready;
    assign w_elem_xfer = r_elem_valid && bus.elem_ready;
    assign w_at_last   = (r_index == LAST_INDEX);

    // Occupancy FSM, index counter, vector slots and registered handshake outputs
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_EMPTY;
            r_index      <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_vec_ready  <= 1'b1;
            r_elem_valid <= 1'b0;
        end else if (i_clear) begin
            // Flush: drop both slots and any handshake seen this cycle.
            // Slot contents are left as they are; they are unreachable
            // until a new vector overwrites the active slot.
            r_state      <= S_EMPTY;
            r_index      <= '0;
            r_vec_ready  <= 1'b1;
            r_elem_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_vec_xfer) begin
                        r_active     <= bus.vec_data;
                        r_index      <= '0;
                        r_state      <= S_ONE;
                        r_vec_ready  <= 1'b1;
                        r_elem_valid <= 1'b1;
                    end
                end

                S_ONE: begin
                    if (w_elem_xfer && w_at_last) begin
                        r_index <= '0;
                        if (w_vec_xfer) begin
                            // New vector goes straight into the slot being vacated.
                            r_active     <= bus.vec_data;
                            r_state      <= S_ONE;
                            r_vec_ready  <= 1'b1;
                            r_elem_valid <= 1'b1;
                        end else begin
                            r_state      <= S_EMPTY;
                            r_vec_ready  <= 1'b1;
                            r_elem_valid <= 1'b0;
                        end
                    end else begin
                        if (w_elem_xfer) begin
                            r_index <= r_index + 1'b1;
                        end
                        if (w_vec_xfer) begin
                            r_pending    <= bus.vec_data;
                            r_state      <= S_TWO;
                            r_vec_ready  <= 1'b0;
                            r_elem_valid <= 1'b1;
                        end
                    end
                end

                S_TWO: begin
                    if (w_elem_xfer) begin
                        if (w_at_last) begin
                            // Promote pending on the same edge: no idle cycle.
                            r_active     <= r_pending;
                            r_index      <= '0;
                            r_state      <= S_ONE;
                            r_vec_ready  <= 1'b1;
                            r_elem_valid <= 1'b1;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state      <= S_EMPTY;
                    r_index      <= '0;
                    r_vec_ready  <= 1'b1;
                    r_elem_valid <= 1'b0;
                end
            endcase
        end
    end

    // Select the active element and decode its row position from the index
    always_comb begin
        w_elem_data   = '0;
        w_row_end_raw = 1'b0;
        for (int k = 0; k < N_ELEMS; k++) begin
            if (r_index == INDEX_WIDTH'(k)) begin
                w_elem_data   = r_active[k*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                w_row_end_raw = ((k % ROW_LENGTH) == (ROW_LENGTH - 1));
            end
        end
    end

    assign bus.vec_ready     = r_vec_ready;
    assign bus.elem_valid    = r_elem_valid;
    assign bus.elem_data     = w_elem_data;
    assign bus.element_index = r_index;
    assign bus.row_end       = w_row_end_raw && r_elem_valid;
    assign bus.vector_end    = w_at_last && r_elem_valid;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_vector_element_serializer.sv
// Directed bench for vector_element_serializer (3x3 vectors of 8-bit elements).
module tb_vector_element_serializer;
  localparam int EW = 8;
  localparam int RL = 3;
  localparam int RC = 3;
  localparam int IW = 4;
  localparam int N  = RL * RC;
  localparam int VW = EW * N;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  vector_element_serializer_if #(
    .ELEMENT_WIDTH(EW), .ROW_LENGTH(RL), .ROW_COUNT(RC), .INDEX_WIDTH(IW)
  ) vif ();

  vector_element_serializer #(
    .ELEMENT_WIDTH(EW), .ROW_LENGTH(RL), .ROW_COUNT(RC), .INDEX_WIDTH(IW)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_clear     (clr),
    .bus         (vif.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] mk_vec(input logic [7:0] base);
    logic [VW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*EW +: EW] = base + 8'(k);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Check every element output against the expected element k of a vector at base
  task automatic chk_elem(input string tag, input int k, input logic [7:0] base);
    chk({tag, ".valid"}, 32'(vif.elem_valid), 32'd1);
    chk({tag, ".index"}, 32'(vif.element_index), 32'(k));
    chk({tag, ".data"}, 32'(vif.elem_data), 32'(base + 8'(k)));
    chk({tag, ".row_end"}, 32'(vif.row_end), 32'((k % RL) == RL - 1));
    chk({tag, ".vector_end"}, 32'(vif.vector_end), 32'(k == N - 1));
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] pat;
    int exp_idx;
    int cyc;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clr = 1'b0;
    vif.vec_valid  = 1'b0;
    vif.vec_data   = '0;
    vif.elem_ready = 1'b0;

    // ---- reset held ----
    @(negedge clk);
    step();
    chk("rst.elem_valid", 32'(vif.elem_valid), 32'd0);
    chk("rst.index", 32'(vif.element_index), 32'd0);
    chk("rst.data", 32'(vif.elem_data), 32'd0);
    chk("rst.row_end", 32'(vif.row_end), 32'd0);
    chk("rst.vector_end", 32'(vif.vector_end), 32'd0);
    rst = 1'b0;
    step();
    chk("rst.vec_ready", 32'(vif.vec_ready), 32'd1);
    chk("rst.state", 32'(dbg_state), 32'd0);

    // ---- single vector 0x10..0x18, elem_ready high ----
    vif.vec_valid  = 1'b1;
    vif.vec_data   = mk_vec(8'h10);
    vif.elem_ready = 1'b1;
    chk("t1.pre_valid", 32'(vif.elem_valid), 32'd0);
    step();
    vif.vec_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk_elem("t1", k, 8'h10);
      step();
    end
    chk("t1.end_valid", 32'(vif.elem_valid), 32'd0);
    chk("t1.end_state", 32'(dbg_state), 32'd0);

    // ---- two vectors back-to-back ----
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'h20);
    step();
    vif.vec_data = mk_vec(8'h30);
    for (int c = 0; c < 2 * N; c++) begin
      chk_elem("t2", c % N, (c < N) ? 8'h20 : 8'h30);
      chk("t2.vec_ready", 32'(vif.vec_ready), 32'((c == 0) || (c >= N)));
      if (c >= 1 && c < N) chk("t2.state_two", 32'(dbg_state), 32'd2);
      step();
      if (c == 0) vif.vec_valid = 1'b0;
    end
    chk("t2.end_valid", 32'(vif.elem_valid), 32'd0);

    // ---- stalls: elem_ready pattern, vec_data churned while idle ----
    vif.vec_valid  = 1'b1;
    vif.vec_data   = mk_vec(8'h40);
    vif.elem_ready = 1'b0;
    step();
    vif.vec_valid = 1'b0;
    pat = 16'b0110_1001_1010_1001;
    exp_idx = 0;
    cyc = 0;
    while (exp_idx < N && cyc < 40) begin
      vif.elem_ready = pat[cyc % 16];
      vif.vec_data   = {VW{1'b0}} | VW'($urandom_range(0, 32'hFFFF));
      chk_elem("t3", exp_idx, 8'h40);
      step();
      if (vif.elem_ready) exp_idx++;
      cyc++;
    end
    chk("t3.delivered", 32'(exp_idx), 32'(N));
    chk("t3.end_valid", 32'(vif.elem_valid), 32'd0);

    // ---- new vector offered on the vector_end transfer ----
    vif.elem_ready = 1'b1;
    vif.vec_valid  = 1'b1;
    vif.vec_data   = mk_vec(8'h50);
    step();
    vif.vec_valid = 1'b0;
    for (int k = 0; k < N - 1; k++) step();
    chk_elem("t4.last", N - 1, 8'h50);
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'h60);
    chk("t4.vec_ready_at_end", 32'(vif.vec_ready), 32'd1);
    step();
    vif.vec_valid = 1'b0;
    chk("t4.state_one", 32'(dbg_state), 32'd1);
    chk("t4.vec_ready", 32'(vif.vec_ready), 32'd1);
    for (int k = 0; k < N; k++) begin
      chk_elem("t4", k, 8'h60);
      step();
    end
    chk("t4.end_valid", 32'(vif.elem_valid), 32'd0);

    // ---- clear at index 4 with a pending vector ----
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'h70);
    step();
    vif.vec_data = mk_vec(8'h80);
    step();
    vif.vec_valid = 1'b0;
    step();
    step();
    step();
    chk_elem("t5.pre", 4, 8'h70);
    chk("t5.pre_state", 32'(dbg_state), 32'd2);
    clr = 1'b1;
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'hE0);
    step();
    clr = 1'b0;
    vif.vec_valid = 1'b0;
    chk("t5.valid", 32'(vif.elem_valid), 32'd0);
    chk("t5.vec_ready", 32'(vif.vec_ready), 32'd1);
    chk("t5.index", 32'(vif.element_index), 32'd0);
    chk("t5.state", 32'(dbg_state), 32'd0);
    step();
    chk("t5.still_idle", 32'(vif.elem_valid), 32'd0);
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'h90);
    step();
    vif.vec_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk_elem("t5.reload", k, 8'h90);
      step();
    end
    chk("t5.end_valid", 32'(vif.elem_valid), 32'd0);

    // ---- asynchronous reset mid-stream at index 6 ----
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'hA0);
    step();
    vif.vec_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk_elem("t6.pre", 6, 8'hA0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.async_valid", 32'(vif.elem_valid), 32'd0);
    chk("t6.async_index", 32'(vif.element_index), 32'd0);
    chk("t6.async_vector_end", 32'(vif.vector_end), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6.no_resume", 32'(vif.elem_valid), 32'd0);
    end
    chk("t6.vec_ready", 32'(vif.vec_ready), 32'd1);
    vif.vec_valid = 1'b1;
    vif.vec_data  = mk_vec(8'hB0);
    step();
    vif.vec_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk_elem("t6.reload", k, 8'hB0);
      step();
    end
    chk("t6.end_valid", 32'(vif.elem_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
